rescale_seq_top: RTL and testbench

Parametrised, time-multiplexed requantisation stage that takes a packed vector of RESCALE_NUM wide signed accumulator values and produces RESCALE_NUM saturated OUTPUT_WIDTH results. It sits between a convolution layer's accumulator array and the next layer's input buffer. It replaces a fixed one-shot shift rescale with a runtime multiplier/shift, round-half-up, optional ReLU and a ready/valid handshake on both sides. LANES elements are processed per cycle through a 2-stage pipeline.

---
 rtl/rescale_seq_top.sv | 178 +++++++++++++++++
 tb/tb_rescale_seq_top.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rescale_seq_top.sv
// Requantises a vector of wide signed accumulators to saturated narrow results using a runtime multiplier and shift, with optional ReLU.
// Latency: BEATS+2 cycles from the accept edge to valid_o, with LANES elements per cycle through a 2-stage pipeline.
// Backpressure: ready_o is low while a vector is in flight; COMMIT waits indefinitely for a free output slot and holds the staged result.
module rescale_seq_top #(
    parameter int INPUT_WIDTH  = 22,
    parameter int OUTPUT_WIDTH = 8,
    parameter int RESCALE_NUM  = 36,
    parameter int LANES        = 6,
    parameter int MULT_WIDTH   = 16,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [INPUT_WIDTH*RESCALE_NUM-1:0]  data_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    input  logic [MULT_WIDTH-1:0]               mult_i,
    input  logic [SHIFT_WIDTH-1:0]              shift_i,
    input  logic                                relu_en_i,
    output logic [OUTPUT_WIDTH*RESCALE_NUM-1:0] data_o,
    output logic                                valid_o,
    input  logic                                ready_i
);

    localparam int BEATS = RESCALE_NUM / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    // Product width: signed input times zero-extended unsigned multiplier.
    localparam int PW    = INPUT_WIDTH + MULT_WIDTH + 1;
    // One extra bit so adding the rounding constant can never overflow.
    localparam int RW    = PW + 1;

    localparam logic signed [RW-1:0] SAT_MAX = RW'(2**(OUTPUT_WIDTH-1) - 1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(2**(OUTPUT_WIDTH-1)));

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic [1:0]                         state;
    logic [CW-1:0]                      cnt;
    logic [INPUT_WIDTH*RESCALE_NUM-1:0] in_buf;
    logic [MULT_WIDTH-1:0]              mult_q;
    logic [SHIFT_WIDTH-1:0]             shift_q;
    logic                               relu_q;

    logic                               s1_vld;
    logic [CW-1:0]                      s1_beat;
    logic signed [PW-1:0]               s1_p      [LANES];
    logic signed [PW-1:0]               lane_prod [LANES];
    logic signed [RW-1:0]               lane_sum  [LANES];
    logic signed [RW-1:0]               lane_r    [LANES];
    logic [OUTPUT_WIDTH-1:0]            lane_res  [LANES];
    logic signed [RW-1:0]               rnd;
    logic signed [RW-1:0]               sat_lo;

    logic [OUTPUT_WIDTH*RESCALE_NUM-1:0] stage_buf;

    logic accept;
    logic out_take;
    logic commit_fire;

    assign ready_o     = (state == IDLE);
    assign accept      = valid_i && ready_o;
    assign out_take    = valid_o && ready_i;
    // The output slot is free if empty or being drained this very cycle.
    assign commit_fire = (state == COMMIT) && (!valid_o || ready_i);

    // Sequencer: accept, issue BEATS beats, let the last one drain, then commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (cnt == CW'(BEATS - 1)) begin
                        state <= DRAIN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= COMMIT;
                end
                COMMIT: begin
                    if (commit_fire) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Input buffer: vector and its scaling controls are frozen for the whole run.
    always_ff @(posedge clk) begin
        if (accept) begin
            in_buf  <= data_i;
            mult_q  <= mult_i;
            shift_q <= shift_i;
            relu_q  <= relu_en_i;
        end
    end

    // Stage 1 multiply for the lanes of the current beat.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_prod[l] = PW'($signed(in_buf[INPUT_WIDTH*(int'(cnt)*LANES + l) +: INPUT_WIDTH]))
                         * PW'($signed({1'b0, mult_q}));
        end
    end

    // Stage 1 valid bit; cleared by reset so an aborted run never reaches staging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= (state == RUN);
        end
    end

    // Stage 1 data registers.
    always_ff @(posedge clk) begin
        s1_beat <= cnt;
        for (int l = 0; l < LANES; l++) begin
            s1_p[l] <= lane_prod[l];
        end
    end

    // Stage 2: round half up, arithmetic shift, then clamp (lower bound 0 under ReLU).
    always_comb begin
        rnd    = (shift_q == '0) ? '0 : (RW'(1) <<< (shift_q - 1'b1));
        sat_lo = relu_q ? '0 : SAT_MIN;
        for (int l = 0; l < LANES; l++) begin
            lane_sum[l] = {s1_p[l][PW-1], s1_p[l]} + rnd;
            lane_r[l]   = lane_sum[l] >>> shift_q;
            if (lane_r[l] > SAT_MAX) begin
                lane_res[l] = SAT_MAX[OUTPUT_WIDTH-1:0];
            end else if (lane_r[l] < sat_lo) begin
                lane_res[l] = sat_lo[OUTPUT_WIDTH-1:0];
            end else begin
                lane_res[l] = lane_r[l][OUTPUT_WIDTH-1:0];
            end
        end
    end

    // Stage 2 register: the staging buffer, written one beat of lanes at a time.
    always_ff @(posedge clk) begin
        if (s1_vld) begin
            for (int l = 0; l < LANES; l++) begin
                stage_buf[OUTPUT_WIDTH*(int'(s1_beat)*LANES + l) +: OUTPUT_WIDTH] <= lane_res[l];
            end
        end
    end

    // Output slot: a commit reload takes priority over the downstream take.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (commit_fire) begin
            valid_o <= 1'b1;
            data_o  <= stage_buf;
        end else if (out_take) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rescale_seq_top.sv
// Directed bench for rescale_seq_top with hand-computed expected vectors.
// Checks latency (8 cycles), rounding, lane mapping, saturation/ReLU, backpressure, async reset and ignored inputs.
// Downstream readiness is driven per test; every wait on the DUT is cycle-bounded.
module tb_rescale_seq_top;

    localparam int IW  = 22;
    localparam int OW  = 8;
    localparam int RN  = 36;
    localparam int DW  = OW * RN;
    localparam int DIW = IW * RN;

    logic            clk;
    logic            rst_n;
    logic [DIW-1:0]  data_i;
    logic            valid_i;
    logic            ready_o;
    logic [15:0]     mult_i;
    logic [4:0]      shift_i;
    logic            relu_en_i;
    logic [DW-1:0]   data_o;
    logic            valid_o;
    logic            ready_i;

    int total = 0;
    int bad   = 0;

    rescale_seq_top dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .mult_i    (mult_i),
        .shift_i   (shift_i),
        .relu_en_i (relu_en_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] fill8(input logic [OW-1:0] v);
        return {RN{v}};
    endfunction

    function automatic logic [DIW-1:0] fill22(input logic [IW-1:0] v);
        return {RN{v}};
    endfunction

    // Waits for ready_o, then presents one vector for exactly one edge (the accept edge).
    task automatic send(input logic [DIW-1:0] d, input logic [15:0] m, input logic [4:0] s, input logic r);
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            tick;
            n++;
        end
        chk("send_ready", DW'(ready_o), DW'(1));
        data_i    = d;
        mult_i    = m;
        shift_i   = s;
        relu_en_i = r;
        valid_i   = 1'b1;
        tick;
        valid_i   = 1'b0;
    endtask

    // Counts edges from the accept edge until valid_o; optionally toggles junk input while ready_o is low.
    task automatic wait_out(input bit noise, output int n);
        n = 0;
        while (!valid_o && n < 40) begin
            if (noise && !ready_o) begin
                valid_i = ~valid_i;
                data_i  = fill22(22'd9);
                mult_i  = 16'd7;
            end else begin
                valid_i = 1'b0;
            end
            tick;
            n++;
        end
        valid_i = 1'b0;
    endtask

    initial begin
        int             lat;
        int             extra;
        logic [DIW-1:0] d;
        logic [DW-1:0]  e;

        rst_n     = 1'b1;
        data_i    = '0;
        valid_i   = 1'b0;
        mult_i    = '0;
        shift_i   = '0;
        relu_en_i = 1'b0;
        ready_i   = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(valid_o), DW'(0));
        chk("rst_data",  data_o,       '0);
        chk("rst_ready", DW'(ready_o), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick;

        // Passthrough: 5 * 1 >> 0 = 5 on every element.
        send(fill22(22'd5), 16'd1, 5'd0, 1'b0);
        chk("pass_busy", DW'(ready_o), DW'(0));
        wait_out(1'b0, lat);
        chk("pass_lat",  DW'(lat), DW'(8));
        chk("pass_data", data_o, fill8(8'h05));
        tick;
        chk("pass_drop", DW'(valid_o), DW'(0));

        // Rounding: 15+2>>2=4, -15+2>>>2=-4, 18+2>>2=5.
        d = '0;
        d[0*IW +: IW] = 22'd5;
        d[1*IW +: IW] = 22'h3FFFFB;
        d[2*IW +: IW] = 22'd6;
        e = '0;
        e[0*OW +: OW] = 8'h04;
        e[1*OW +: OW] = 8'hFC;
        e[2*OW +: OW] = 8'h05;
        send(d, 16'd3, 5'd2, 1'b0);
        wait_out(1'b0, lat);
        chk("rnd_lat",  DW'(lat), DW'(8));
        chk("rnd_data", data_o, e);
        tick;

        // Lane/beat mapping: out_i = i.
        for (int i = 0; i < RN; i++) begin
            d[IW*i +: IW] = IW'(i);
            e[OW*i +: OW] = OW'(i);
        end
        send(d, 16'd1, 5'd0, 1'b0);
        wait_out(1'b0, lat);
        chk("idx_data", data_o, e);
        tick;

        // Saturation: +-1000 * 1000 clamps to 127 / -128.
        d = '0;
        d[0*IW +: IW] = 22'd1000;
        d[1*IW +: IW] = IW'(-1000);
        e = '0;
        e[0*OW +: OW] = 8'h7F;
        e[1*OW +: OW] = 8'h80;
        send(d, 16'd1000, 5'd0, 1'b0);
        wait_out(1'b0, lat);
        chk("sat_data", data_o, e);
        tick;

        // Same with ReLU: negative side clamps to 0.
        e[1*OW +: OW] = 8'h00;
        send(d, 16'd1000, 5'd0, 1'b1);
        wait_out(1'b0, lat);
        chk("relu_sat", data_o, e);
        tick;

        // ReLU in range: 50 passes, -7 -> 0.
        d = '0;
        d[0*IW +: IW] = 22'd50;
        d[1*IW +: IW] = IW'(-7);
        e = '0;
        e[0*OW +: OW] = 8'h32;
        send(d, 16'd1, 5'd0, 1'b1);
        wait_out(1'b0, lat);
        chk("relu_pass", data_o, e);
        tick;

        // Backpressure: A sits in data_o while B stalls in COMMIT.
        ready_i = 1'b0;
        send(fill22(22'd1), 16'd1, 5'd0, 1'b0);
        wait_out(1'b0, lat);
        chk("bp_a_lat", DW'(lat), DW'(8));
        send(fill22(22'd2), 16'd1, 5'd0, 1'b0);
        repeat (12) tick;
        chk("bp_hold_data",  data_o,       fill8(8'h01));
        chk("bp_hold_valid", DW'(valid_o), DW'(1));
        chk("bp_hold_ready", DW'(ready_o), DW'(0));
        ready_i = 1'b1;
        tick;
        ready_i = 1'b0;
        chk("bp_b_data",  data_o,       fill8(8'h02));
        chk("bp_b_valid", DW'(valid_o), DW'(1));
        chk("bp_b_ready", DW'(ready_o), DW'(1));
        ready_i = 1'b1;
        tick;
        chk("bp_drain", DW'(valid_o), DW'(0));

        // Async reset during beat 3 of RUN.
        send(fill22(22'd3), 16'd1, 5'd0, 1'b0);
        repeat (3) tick;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", DW'(valid_o), DW'(0));
        chk("mid_rst_data",  data_o,       '0);
        chk("mid_rst_ready", DW'(ready_o), DW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        // 7*2 = 14, +1 >> 1 = 7.
        send(fill22(22'd7), 16'd2, 5'd1, 1'b0);
        wait_out(1'b0, lat);
        chk("post_rst_lat",  DW'(lat), DW'(8));
        chk("post_rst_data", data_o,   fill8(8'h07));
        tick;

        // Junk valid_i while busy must be ignored.
        send(fill22(22'd4), 16'd1, 5'd0, 1'b0);
        wait_out(1'b1, lat);
        chk("ign_lat",  DW'(lat), DW'(8));
        chk("ign_data", data_o,   fill8(8'h04));
        tick;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            if (valid_o) extra++;
            tick;
        end
        chk("ign_no_second", DW'(extra), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
